// File: rtl/cam_capture_fsm_if.sv
// Camera byte stream in, framebuffer write port and frame status out.
// The slave modport is the capture engine; the master modport is the camera/memory side.
interface cam_capture_fsm_if #(
   parameter int AW = 15,
   parameter int DW = 3
);
   logic [7:0]    data;
   logic          vsync;
   logic          href;
   logic          snap;
   logic          arm;
   logic [AW-1:0] mem_px_addr;
   logic [DW-1:0] mem_px_data;
   logic          px_wr;
   logic          frame_done;
   logic          frame_err;
   logic          busy;

   modport slave (
      input  data, vsync, href, snap, arm,
      output mem_px_addr, mem_px_data, px_wr, frame_done, frame_err, busy
   );

   modport master (
      output data, vsync, href, snap, arm,
      input  mem_px_addr, mem_px_data, px_wr, frame_done, frame_err, busy
   );
endinterface

// File: rtl/cam_capture_fsm.sv
// RGB444 camera capture into a frame memory with DW-bit pixels, snapshot/continuous modes.
// Optional 2:1 decimation in both axes when CAM_CAPTURE_DECIM_EN is defined.
module cam_capture_fsm #(
   parameter int AW      = 15,
   parameter int DW      = 3,
   parameter int H_PIX   = 160,
   parameter int V_LINES = 120
) (
   input  logic             pclk,
   input  logic             rst,
   cam_capture_fsm_if.slave bus
);
   localparam int CW = $clog2(H_PIX + 1);
   localparam int LW = $clog2(V_LINES + 1);
   localparam logic [CW-1:0] H_MAX = CW'(H_PIX);
   localparam logic [LW-1:0] L_MAX = LW'(V_LINES);

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t        state;
   logic          vsync_q, href_q, armed, phase, line_stored;
   logic [CW-1:0] col;
   logic [LW-1:0] line;
   logic [AW-1:0] addr;
   logic [3:0]    red_p0;
   logic          vs_rise, vs_fall, hr_rise, hr_fall, ph, px_done, col_adv, px_keep;
`ifdef CAM_CAPTURE_DECIM_EN
   logic          src_col_odd, src_line_odd, line_seen;
`endif

   function automatic logic [DW-1:0] px_conv(input logic [3:0] r, input logic [3:0] g,
                                              input logic [3:0] b);
      logic [11:0] w;
      w = '0;
      if (DW == 3)      w[2:0] = {r[3], g[3], b[3]};
      else if (DW == 8) w[7:0] = {r[3:1], g[3:1], b[3:2]};
      else              w      = {r, g, b};
      return w[DW-1:0];
   endfunction

   always_comb begin
      vs_rise = bus.vsync & ~vsync_q;
      vs_fall = vsync_q & ~bus.vsync;
      hr_rise = bus.href & ~href_q;
      hr_fall = href_q & ~bus.href;
      // A new line always starts on the R byte, whatever the previous line left behind.
      ph      = hr_rise ? 1'b0 : phase;
      px_done = (state == CAPTURE) && bus.href && ph && !vs_rise;
      col_adv = px_done;
`ifdef CAM_CAPTURE_DECIM_EN
      col_adv = px_done && !src_col_odd && !src_line_odd;
`endif
      px_keep = col_adv && (col < H_MAX) && (line < L_MAX);
   end

   // Stage p0: red nibble of the pixel in flight
   always_ff @(posedge pclk) begin
      if ((state == CAPTURE) && bus.href && !ph) red_p0 <= bus.data[3:0];
   end

   // Stage p1: registered write port, position counters and frame status
   always_ff @(posedge pclk) begin
      if (!rst) begin
         state           <= IDLE;
         vsync_q         <= 1'b0;
         href_q          <= 1'b0;
         armed           <= 1'b0;
         phase           <= 1'b0;
         line_stored     <= 1'b0;
         col             <= '0;
         line            <= '0;
         addr            <= '0;
         bus.mem_px_addr <= '0;
         bus.mem_px_data <= '0;
         bus.px_wr       <= 1'b0;
         bus.frame_done  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.busy        <= 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
         src_col_odd     <= 1'b0;
         src_line_odd    <= 1'b0;
         line_seen       <= 1'b0;
`endif
      end else begin
         vsync_q        <= bus.vsync;
         href_q         <= bus.href;
         bus.px_wr      <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (vs_fall && (!bus.snap || armed)) begin
                  state       <= CAPTURE;
                  bus.busy    <= 1'b1;
                  phase       <= 1'b0;
                  line_stored <= 1'b0;
                  col         <= '0;
                  line        <= '0;
                  addr        <= '0;
                  if (bus.snap) armed <= 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
                  src_line_odd <= 1'b0;
                  line_seen    <= 1'b0;
`endif
               end
            end
            CAPTURE: begin
               if (vs_rise) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  if ((line == L_MAX) && !bus.href) bus.frame_done <= 1'b1;
                  else                              bus.frame_err  <= 1'b1;
               end else if (bus.href) begin
                  phase <= ~ph;
                  if (col_adv && (col < H_MAX)) col <= col + 1'b1;
                  if (px_keep) begin
                     bus.px_wr       <= 1'b1;
                     bus.mem_px_addr <= addr;
                     bus.mem_px_data <= px_conv(red_p0, bus.data[7:4], bus.data[3:0]);
                     addr            <= addr + 1'b1;
                     line_stored     <= 1'b1;
                  end
`ifdef CAM_CAPTURE_DECIM_EN
                  if (hr_rise)      src_col_odd <= 1'b0;
                  else if (px_done) src_col_odd <= ~src_col_odd;
                  if (px_done)      line_seen   <= 1'b1;
`endif
               end else if (hr_fall) begin
                  phase       <= 1'b0;
                  col         <= '0;
                  line_stored <= 1'b0;
                  if (line_stored) line <= line + 1'b1;
`ifdef CAM_CAPTURE_DECIM_EN
                  if (line_seen) src_line_odd <= ~src_line_odd;
                  line_seen <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
         if (bus.arm) armed <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cam_capture_fsm.sv
// Directed bench: two capture engines (DW=3 and DW=8, 4x2 frame) driven by one camera stream.
module tb_cam_capture_fsm;
   logic       pclk = 1'b0;
   logic       rst  = 1'b0;
   logic [7:0] data = 8'h00;
   logic       vsync = 1'b1, href = 1'b0, snap = 1'b0, arm = 1'b0;

   int n_vec = 0, n_err = 0;
   int n_done = 0, n_ferr = 0;
   logic [3:0] wa[$];
   logic [2:0] wd3[$];
   logic [7:0] wd8[$];
   logic fd, fe, fd2;

   always #5 pclk = ~pclk;

   cam_capture_fsm_if #(.AW(4), .DW(3)) c3();
   cam_capture_fsm_if #(.AW(4), .DW(8)) c8();

   assign c3.data = data;  assign c8.data = data;
   assign c3.vsync = vsync; assign c8.vsync = vsync;
   assign c3.href = href;  assign c8.href = href;
   assign c3.snap = snap;  assign c8.snap = snap;
   assign c3.arm = arm;    assign c8.arm = arm;

   cam_capture_fsm #(.AW(4), .DW(3), .H_PIX(4), .V_LINES(2)) dut3 (
      .pclk(pclk), .rst(rst), .bus(c3.slave));
   cam_capture_fsm #(.AW(4), .DW(8), .H_PIX(4), .V_LINES(2)) dut8 (
      .pclk(pclk), .rst(rst), .bus(c8.slave));

   always @(negedge pclk) begin
      if (c3.px_wr) begin
         wa.push_back(c3.mem_px_addr);
         wd3.push_back(c3.mem_px_data);
      end
      if (c8.px_wr) wd8.push_back(c8.mem_px_data);
      if (c3.frame_done) n_done++;
      if (c3.frame_err) n_ferr++;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic clr();
      wa.delete(); wd3.delete(); wd8.delete();
      n_done = 0; n_ferr = 0;
   endtask

   task automatic pixel(input logic [7:0] b0, input logic [7:0] b1);
      data = b0; cyc();
      data = b1; cyc();
   endtask

   task automatic line_px(input int n, input logic [7:0] b0, input logic [7:0] b1);
      href = 1'b1;
      repeat (n) pixel(b0, b1);
      href = 1'b0;
      cyc(2);
   endtask

   task automatic frame_start();
      vsync = 1'b1; cyc(2);
      vsync = 1'b0; cyc(2);
   endtask

   task automatic frame_end();
      vsync = 1'b1; cyc();
      fd = c3.frame_done; fe = c3.frame_err;
      cyc();
      fd2 = c3.frame_done;
   endtask

   task automatic test_reset();
      rst = 1'b0; cyc(2);
      n_vec++; if (c3.px_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", c3.px_wr); end
      n_vec++; if (c3.mem_px_addr !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", c3.mem_px_addr); end
      n_vec++; if (c3.mem_px_data !== 3'd0) begin n_err++; $display("FAIL rst_data: got %b want 000", c3.mem_px_data); end
      n_vec++; if ({c3.frame_done, c3.frame_err, c3.busy} !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b want 000", {c3.frame_done, c3.frame_err, c3.busy}); end
      n_vec++; if (c8.mem_px_data !== 8'd0) begin n_err++; $display("FAIL rst_data8: got %h want 00", c8.mem_px_data); end
      rst = 1'b1; cyc();
   endtask

   task automatic test_full_frame();
      clr();
      frame_start();
      line_px(4, 8'h0F, 8'h80);
      line_px(4, 8'h0F, 8'h80);
      n_vec++; if (c3.busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", c3.busy); end
      frame_end();
      n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", fd); end
      n_vec++; if (fe !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", fe); end
      n_vec++; if (fd2 !== 1'b0) begin n_err++; $display("FAIL full_done_pulse: got %b want 0", fd2); end
      n_vec++; if (wa.size() !== 8) begin n_err++; $display("FAIL full_count: got %0d want 8", wa.size()); end
      for (int i = 0; i < wa.size(); i++) begin
         n_vec++; if (wa[i] !== 4'(i)) begin n_err++; $display("FAIL full_addr%0d: got %0d want %0d", i, wa[i], i); end
         n_vec++; if (wd3[i] !== 3'b110) begin n_err++; $display("FAIL full_data%0d: got %b want 110", i, wd3[i]); end
         n_vec++; if (wd8[i] !== 8'b1111_0000) begin n_err++; $display("FAIL full_data8_%0d: got %b want 11110000", i, wd8[i]); end
      end
      n_vec++; if (c3.mem_px_addr !== 4'd7) begin n_err++; $display("FAIL full_addr_hold: got %0d want 7", c3.mem_px_addr); end
      n_vec++; if (c3.busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end: got %b want 0", c3.busy); end
   endtask

   task automatic test_dw8();
      clr();
      frame_start();
      line_px(4, 8'h0A, 8'h5C);
      line_px(4, 8'h0A, 8'h5C);
      frame_end();
      n_vec++; if (wd8.size() !== 8) begin n_err++; $display("FAIL dw8_count: got %0d want 8", wd8.size()); end
      for (int i = 0; i < wd8.size(); i++) begin
         n_vec++; if (wd8[i] !== 8'b101_010_11) begin n_err++; $display("FAIL dw8_data%0d: got %b want 10101011", i, wd8[i]); end
      end
      for (int i = 0; i < wd3.size(); i++) begin
         n_vec++; if (wd3[i] !== 3'b101) begin n_err++; $display("FAIL dw3_thresh%0d: got %b want 101", i, wd3[i]); end
      end
      n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL dw8_done: got %b want 1", fd); end
   endtask

   task automatic test_short_frame();
      clr();
      frame_start();
      line_px(4, 8'h0F, 8'h80);
      frame_end();
      n_vec++; if (wa.size() !== 4) begin n_err++; $display("FAIL short_count: got %0d want 4", wa.size()); end
      n_vec++; if (fe !== 1'b1) begin n_err++; $display("FAIL short_err: got %b want 1", fe); end
      n_vec++; if (fd !== 1'b0) begin n_err++; $display("FAIL short_done: got %b want 0", fd); end
   endtask

   task automatic test_excess();
      clr();
      frame_start();
      repeat (3) line_px(6, 8'h0F, 8'h80);
      frame_end();
      n_vec++; if (wa.size() !== 8) begin n_err++; $display("FAIL excess_count: got %0d want 8", wa.size()); end
      if (wa.size() > 0) begin
         n_vec++; if (wa[wa.size()-1] !== 4'd7) begin n_err++; $display("FAIL excess_last: got %0d want 7", wa[wa.size()-1]); end
      end
      n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL excess_done: got %b want 1", fd); end
      n_vec++; if (c3.mem_px_addr !== 4'd7) begin n_err++; $display("FAIL excess_hold: got %0d want 7", c3.mem_px_addr); end
   endtask

   task automatic test_snapshot();
      clr();
      snap = 1'b1;
      repeat (2) begin
         frame_start();
         line_px(4, 8'h0F, 8'h80);
         line_px(4, 8'h0F, 8'h80);
         frame_end();
      end
      n_vec++; if (wa.size() !== 0) begin n_err++; $display("FAIL snap_noarm: got %0d writes want 0", wa.size()); end
      n_vec++; if ((n_done + n_ferr) !== 0) begin n_err++; $display("FAIL snap_noarm_status: got %0d pulses want 0", n_done + n_ferr); end
      arm = 1'b1; cyc();
      arm = 1'b0; cyc();
      repeat (2) begin
         frame_start();
         line_px(4, 8'h0F, 8'h80);
         line_px(4, 8'h0F, 8'h80);
         frame_end();
      end
      n_vec++; if (wa.size() !== 8) begin n_err++; $display("FAIL snap_armed: got %0d writes want 8", wa.size()); end
      n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL snap_done: got %0d want 1", n_done); end
      snap = 1'b0;
   endtask

   task automatic test_midline_reset();
      clr();
      frame_start();
      href = 1'b1;
      pixel(8'h0F, 8'h80);
      pixel(8'h0F, 8'h80);
      data = 8'h0F; rst = 1'b0; cyc();
      n_vec++; if ({c3.px_wr, c3.busy, c3.frame_done, c3.frame_err} !== 4'b0000) begin n_err++; $display("FAIL mrst_ctrl: got %b want 0000", {c3.px_wr, c3.busy, c3.frame_done, c3.frame_err}); end
      n_vec++; if (c3.mem_px_addr !== 4'd0) begin n_err++; $display("FAIL mrst_addr: got %0d want 0", c3.mem_px_addr); end
      n_vec++; if (c3.mem_px_data !== 3'd0) begin n_err++; $display("FAIL mrst_data: got %b want 000", c3.mem_px_data); end
      rst = 1'b1;
      data = 8'h80; cyc();
      pixel(8'h0F, 8'h80);
      href = 1'b0; cyc(2);
      n_vec++; if (wa.size() !== 2) begin n_err++; $display("FAIL mrst_idle: got %0d writes want 2", wa.size()); end
      frame_start();
      n_vec++; if ((n_done + n_ferr) !== 0) begin n_err++; $display("FAIL mrst_status: got %0d pulses want 0", n_done + n_ferr); end
      line_px(4, 8'h0F, 8'h80);
      line_px(4, 8'h0F, 8'h80);
      frame_end();
      n_vec++; if (wa.size() !== 10) begin n_err++; $display("FAIL mrst_count: got %0d want 10", wa.size()); end
      if (wa.size() > 2) begin
         n_vec++; if (wa[2] !== 4'd0) begin n_err++; $display("FAIL mrst_restart: got %0d want 0", wa[2]); end
      end
      n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL mrst_done: got %b want 1", fd); end
   endtask

   task automatic test_vsync_wins();
      clr();
      frame_start();
      line_px(4, 8'h0F, 8'h80);
      href = 1'b1;
      data = 8'h0F; cyc();
      data = 8'h80; vsync = 1'b1; cyc();
      n_vec++; if (c3.px_wr !== 1'b0) begin n_err++; $display("FAIL vwin_wr: got %b want 0", c3.px_wr); end
      n_vec++; if ({c3.frame_err, c3.frame_done} !== 2'b10) begin n_err++; $display("FAIL vwin_status: got %b want 10", {c3.frame_err, c3.frame_done}); end
      href = 1'b0; cyc(2);
      n_vec++; if (wa.size() !== 4) begin n_err++; $display("FAIL vwin_count: got %0d want 4", wa.size()); end
   endtask

   task automatic test_href_glitch();
      clr();
      frame_start();
      href = 1'b1; data = 8'h0F; cyc();
      href = 1'b0; cyc(2);
      line_px(4, 8'h0A, 8'h5C);
      line_px(4, 8'h0A, 8'h5C);
      frame_end();
      n_vec++; if (wa.size() !== 8) begin n_err++; $display("FAIL glitch_count: got %0d want 8", wa.size()); end
      if (wa.size() > 0) begin
         n_vec++; if (wa[0] !== 4'd0) begin n_err++; $display("FAIL glitch_addr0: got %0d want 0", wa[0]); end
         n_vec++; if (wd8[0] !== 8'b101_010_11) begin n_err++; $display("FAIL glitch_data0: got %b want 10101011", wd8[0]); end
      end
      n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL glitch_done: got %b want 1", fd); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_dw8();
      test_short_frame();
      test_excess();
      test_snapshot();
      test_midline_reset();
      test_vsync_wins();
      test_href_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cam_capture_fsm.md
# cam_capture_fsm

Parametrised camera-to-framebuffer capture engine. Samples the camera's 8-bit RGB444 two-byte-per-pixel stream on `pclk`, qualifies it with `vsync`/`href`, tracks column and line position, converts each pixel to the framebuffer colour depth selected by `DW`, and issues single-cycle writes to the dual-port frame memory. It replaces the fixed-QQVGA, RGB111-only capture FSM and adds resolution parameters, selectable colour depth, snapshot/continuous modes and frame completion/error status.

## Interface
- `AW`, 15: framebuffer address width; `2**AW` must be >= `H_PIX*V_LINES`.
- `DW`, 3: pixel width in memory; legal values are 3 (RGB111), 8 (RGB332) and 12 (RGB444).
- `H_PIX`, 160: pixels stored per line.
- `V_LINES`, 120: lines stored per frame.

- `pclk`  in  1  camera pixel clock; sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `data`  in  8  camera byte. Byte 0 is `xxxxRRRR`; byte 1 is `GGGGBBBB`.
- `vsync`  in  1  frame sync, high between frames.
- `href`  in  1  line valid, high while bytes are valid.
- `snap`  in  1  0 selects continuous capture; 1 selects capture of one frame per `arm` pulse.
- `arm`  in  1  one-cycle pulse that enables the next frame in snapshot mode; ignored in continuous mode.
- `mem_px_addr`  out  AW  write address.
- `mem_px_data`  out  DW  write data.
- `px_wr`  out  1  write strobe, one cycle per stored pixel.
- `frame_done`  out  1  one-cycle pulse: frame ended with exactly `V_LINES` lines.
- `frame_err`  out  1  one-cycle pulse: frame ended short, or `vsync` rose mid-line.
- `busy`  out  1  high in CAPTURE state.

## Operation
- `vsync_q` and `href_q` register the previous `vsync` and `href` values.
- States:
  - IDLE: waits for a `vsync` falling edge (`vsync_q=1`, `vsync=0`). Continuous mode moves to CAPTURE. Snapshot mode moves to CAPTURE only if the armed flag is set, and the flag clears at that point.
  - CAPTURE: stores pixels. A `vsync` rising edge moves to IDLE.
- Armed flag is set by `arm` in any state and cleared on reset.
- Byte phase: resets to 0 on the `href` rising edge and toggles on each `href`-high cycle in CAPTURE.
  - Phase 0 latches R.
  - Phase 1 completes the pixel.
- `col` (0..`H_PIX`) increments on each completed pixel and clears at the `href` falling edge.
- `line` (0..`V_LINES`) increments at the `href` falling edge only if the line stored at least one pixel. It clears on entry to CAPTURE.
- A pixel is stored only if `col < H_PIX` and `line < V_LINES`. Excess pixels and lines are dropped silently, with no write and no address change.
- Address is `line*H_PIX + col`, kept incrementally: reset to 0 on CAPTURE entry, +1 after each stored pixel. No multiplier. It never exceeds `H_PIX*V_LINES-1`.
- Colour conversion, from 4-bit R/G/B:
  - DW=3: `{R[3],G[3],B[3]}`, which is the >=8 threshold.
  - DW=8: `{R[3:1],G[3:1],B[3:2]}`.
  - DW=12: `{R,G,B}`.
- End of frame, on the `vsync` rising edge in CAPTURE:
  - `frame_done` pulses if `line==V_LINES` and `href` is low.
  - Otherwise `frame_err` pulses.
  - `vsync` rising in IDLE produces no pulse.

## Timing
- Reset values: state IDLE, `mem_px_addr`=0, `mem_px_data`=0, `px_wr`=0, `frame_done`=0, `frame_err`=0, `busy`=0, armed=0, `vsync_q`=0, `href_q`=0.
- Reset mid-frame aborts capture with no status pulse. The block then waits for a full `vsync` high-to-low transition before capturing.
- Write latency: `px_wr`, `mem_px_addr` and `mem_px_data` are registered and valid together in the cycle after the phase-1 byte is sampled. `px_wr` is high for exactly 1 cycle.
- `mem_px_addr` and `mem_px_data` hold their values between writes.
- `frame_done` and `frame_err` assert the cycle after the `vsync` rising edge. They are mutually exclusive.
- An `href` glitch that drops to 0 after only a phase-0 byte discards the half pixel.
- If a `vsync` rise and a phase-1 byte occur in the same cycle, `vsync` wins and no write is issued.

## Configuration
- `CAM_CAPTURE_DECIM_EN` defined: 2:1 decimation in both axes for VGA/QVGA sources.
  - Only even camera pixels (source column bit 0 = 0) and even camera lines are stored.
  - `col`, `line` and address advance only on stored pixels and lines.
  - `H_PIX` and `V_LINES` describe the stored (decimated) size.
- Not defined: every pixel and every line is candidate for storage.

## Test plan
- `DW`=3, `H_PIX`=4, `V_LINES`=2, continuous mode; full frame with byte pairs `0x0F`,`0x80` -> 8 writes at addresses 0..7 with data `3'b110`; `frame_done`=1 one cycle after `vsync` rises.
- `DW`=8, same frame with bytes `0x0A`,`0x5C` -> each write carries `8'b101_010_11`.
- Frame with only 1 line, then `vsync` rises -> 4 writes, `frame_err`=1, `frame_done`=0.
- Lines of 6 pixels and 3 lines with `H_PIX`=4, `V_LINES`=2 -> exactly 8 writes, last address 7, `frame_done`=1.
- Snapshot mode with no `arm`, 2 frames -> 0 writes. Then `arm` pulse followed by 2 frames -> only the first frame is written.
- `rst`=0 for 1 cycle mid-line -> all outputs return to reset values. No writes occur until the next `vsync` fall, after which capture restarts at address 0.
